// File: rtl/valet_tip_generator.sv
// Valet retrieval timer: queues ticket requests, times each retrieval and emits one graded, signed tip event.
// Optional streak bonus enabled by defining VALET_TIP_STREAK_EN.
module valet_tip_generator #(
  parameter int TICKET_W          = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter int FAST_CYCLES       = 8,
  parameter int ONTIME_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES    = 40,
  parameter int BONUS_TIP         = 10,
  parameter int BASE_TIP          = 5,
  parameter int LATE_PENALTY      = 3,
  parameter int TIMEOUT_PENALTY   = 15,
  parameter int WRONG_CAR_PENALTY = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [TICKET_W-1:0]           req_ticket,
  output logic                          req_ready,
  input  logic                          car_delivered,
  input  logic [TICKET_W-1:0]           delivered_ticket,
  output logic signed [7:0]             tip_delta,
  output logic                          tip_event_valid,
  output logic                          busy,
  output logic [TICKET_W-1:0]           active_ticket,
  output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EL_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [EL_W-1:0]   FAST_EL    = EL_W'(FAST_CYCLES);
  localparam logic [EL_W-1:0]   ONTIME_EL  = EL_W'(ONTIME_CYCLES);
  localparam logic [EL_W-1:0]   TIMEOUT_EL = EL_W'(TIMEOUT_CYCLES);
  localparam logic signed [9:0] BONUS10    = 10'(BONUS_TIP);
  localparam logic signed [9:0] BASE10     = 10'(BASE_TIP);
  localparam logic signed [9:0] LATE10     = 10'(LATE_PENALTY);
  localparam logic signed [9:0] TIMEOUT10  = 10'(TIMEOUT_PENALTY);
  localparam logic signed [9:0] WRONG10    = 10'(WRONG_CAR_PENALTY);

  typedef enum logic [1:0] {IDLE, RETRIEVE, GRADE} state_t;

  state_t                state_reg, state_next;
  logic [TICKET_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [EL_W-1:0]       elapsed_reg;
  logic                  push, pop, decide, ticket_match;
  logic signed [9:0]     grade_base, grade_total;
  logic signed [7:0]     grade_sat;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign req_ready       = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push            = req_valid && req_ready;
  assign pop             = (state_reg == IDLE) && (count_reg != '0);
  assign ticket_match    = (delivered_ticket == active_ticket);
  assign busy            = (state_reg == RETRIEVE);
  assign tip_event_valid = (state_reg == GRADE);
  assign queue_count     = count_reg;

  always_comb begin
    state_next = state_reg;
    decide     = 1'b0;
    grade_base = '0;
    case (state_reg)
      IDLE: if (pop) state_next = RETRIEVE;
      RETRIEVE: begin
        // A delivery in the timeout cycle still counts as a delivery.
        if (car_delivered) begin
          decide = 1'b1;
          if (!ticket_match)                grade_base = -WRONG10;
          else if (elapsed_reg <= FAST_EL)   grade_base = BONUS10;
          else if (elapsed_reg <= ONTIME_EL) grade_base = BASE10;
          else                               grade_base = -LATE10;
        end else if (elapsed_reg == TIMEOUT_EL) begin
          decide     = 1'b1;
          grade_base = -TIMEOUT10;
        end
        if (decide) state_next = GRADE;
      end
      GRADE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef VALET_TIP_STREAK_EN
  logic [2:0] streak_reg, streak_inc;
  logic       on_time;

  always_comb begin
    on_time     = car_delivered && ticket_match && (elapsed_reg <= ONTIME_EL);
    streak_inc  = (streak_reg == 3'd7) ? 3'd7 : streak_reg + 3'd1;
    grade_total = grade_base;
    if (on_time && (streak_inc >= 3'd3)) grade_total = grade_base + 10'sd2;
  end

  always_ff @(posedge clk) begin
    if (rst)         streak_reg <= '0;
    else if (decide) streak_reg <= on_time ? streak_inc : 3'd0;
  end
`else
  assign grade_total = grade_base;
`endif

  always_comb begin
    if (grade_total > 10'sd127)       grade_sat = 8'sd127;
    else if (grade_total < -10'sd128) grade_sat = -8'sd128;
    else                              grade_sat = grade_total[7:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= req_ticket;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      elapsed_reg   <= '0;
      active_ticket <= '0;
      tip_delta     <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
      if (pop) begin
        active_ticket <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        elapsed_reg   <= '0;
      end else if ((state_reg == RETRIEVE) && (elapsed_reg != TIMEOUT_EL)) begin
        elapsed_reg <= elapsed_reg + EL_W'(1);
      end
      if (decide) tip_delta <= grade_sat;
    end
  end

endmodule

// File: tb/tb_valet_tip_generator.sv
// Self-checking bench for valet_tip_generator: directed scenarios plus randomized retrievals
// compared against a transaction-level grading model (streak rule follows VALET_TIP_STREAK_EN).
module tb_valet_tip_generator;
  localparam int FAST = 8, ONTIME = 20, TMO = 40;
  localparam int BONUS = 10, BASE = 5, LATE = 3, TPEN = 15, WPEN = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [3:0]        req_ticket = '0;
  logic              req_ready;
  logic              car_delivered = 1'b0;
  logic [3:0]        delivered_ticket = '0;
  logic signed [7:0] tip_delta;
  logic              tip_event_valid;
  logic              busy;
  logic [3:0]        active_ticket;
  logic [2:0]        queue_count;

  int         n_checks = 0;
  int         n_errors = 0;
  int         ev_count = 0;
  int         m_streak = 0;
  logic [3:0] cur_ticket = '0;
  logic [3:0] mq[$];

  valet_tip_generator #(
    .TICKET_W(4), .FIFO_DEPTH(4), .FAST_CYCLES(FAST), .ONTIME_CYCLES(ONTIME),
    .TIMEOUT_CYCLES(TMO), .BONUS_TIP(BONUS), .BASE_TIP(BASE), .LATE_PENALTY(LATE),
    .TIMEOUT_PENALTY(TPEN), .WRONG_CAR_PENALTY(WPEN)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ticket(req_ticket),
    .req_ready(req_ready), .car_delivered(car_delivered),
    .delivered_ticket(delivered_ticket), .tip_delta(tip_delta),
    .tip_event_valid(tip_event_valid), .busy(busy),
    .active_ticket(active_ticket), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tip_event_valid === 1'b1) ev_count <= ev_count + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Grade of one retrieval from its outcome, with the optional streak rule.
  function automatic int expect_tip(input bit delivered, input bit match, input int e);
    int  g;
    bit  good;
    good = 1'b0;
    if (!delivered)       g = -TPEN;
    else if (!match)      g = -WPEN;
    else if (e <= FAST)   begin g = BONUS; good = 1'b1; end
    else if (e <= ONTIME) begin g = BASE;  good = 1'b1; end
    else                  g = -LATE;
`ifdef VALET_TIP_STREAK_EN
    if (good) begin
      m_streak = (m_streak >= 7) ? 7 : m_streak + 1;
      if (m_streak >= 3) g += 2;
    end else m_streak = 0;
`endif
    if (g > 127) g = 127;
    if (g < -128) g = -128;
    return g;
  endfunction

  // From idle with an empty queue: push one ticket and return just after it is popped.
  task automatic push_idle(input logic [3:0] t);
    @(negedge clk); req_valid = 1'b1; req_ticket = t;
    @(negedge clk); req_valid = 1'b0;
    check_eq("qcount_one", queue_count, 1);
    @(negedge clk);
    cur_ticket = t;
    check_eq("active_ticket", active_ticket, t);
    check_eq("busy_start", busy, 1);
  endtask

  // Called at the negedge where 'skip' cycles of the retrieval have already elapsed.
  task automatic serve(input logic [3:0] dt, input bit deliver, input int e, input int skip);
    int evs0, exp;
    evs0 = ev_count;
    if (deliver) begin
      repeat (e - skip) @(negedge clk);
      car_delivered = 1'b1; delivered_ticket = dt;
    end else begin
      repeat (TMO - skip) @(negedge clk);
    end
    exp = expect_tip(deliver, dt == cur_ticket, e);
    @(posedge clk); #1;
    check_eq("tip_valid_hi", tip_event_valid, 1);
    check_eq("tip_delta", tip_delta, exp);
    check_eq("busy_grade", busy, 0);
    @(negedge clk); car_delivered = 1'b0;
    @(posedge clk); #1;
    check_eq("tip_valid_lo", tip_event_valid, 0);
    check_eq("tip_hold", tip_delta, exp);
    check_eq("one_event", ev_count - evs0, 1);
    $display("txn ticket=%0d deliver=%0b dt=%0d elapsed=%0d tip=%0d", cur_ticket, deliver, dt, e, exp);
  endtask

  initial begin
    logic [3:0] tk, dt;
    int         evs, e, last;
    bit         dl;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_tip", tip_delta, 0);
    check_eq("rst_valid", tip_event_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_active", active_ticket, 0);
    check_eq("rst_qcount", queue_count, 0);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_events", ev_count, 0);

    push_idle(4'd3); serve(4'd3, 1, 8, 0);
    push_idle(4'd3); serve(4'd3, 1, 9, 0);
    push_idle(4'd3); serve(4'd3, 1, 20, 0);
    push_idle(4'd5); serve(4'd5, 1, 21, 0);
    push_idle(4'd6); serve(4'd6, 0, TMO, 0);
    push_idle(4'd2); serve(4'd9, 1, 5, 0);
    push_idle(4'd2); serve(4'd2, 1, TMO, 0);
    last = TMO;

    // Stray delivery while idle
    evs = ev_count;
    @(negedge clk); car_delivered = 1'b1; delivered_ticket = 4'd2;
    @(posedge clk); #1;
    check_eq("stray_valid", tip_event_valid, 0);
    check_eq("stray_busy", busy, 0);
    @(negedge clk); car_delivered = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("stray_events", ev_count - evs, 0);
    check_eq("stray_hold", tip_delta, -LATE);

    // Queue fill while busy, then FIFO-order service
    @(negedge clk); req_valid = 1'b1; req_ticket = 4'hA;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); cur_ticket = 4'hA;
    check_eq("q_active", active_ticket, 4'hA);
    for (int i = 0; i < 5; i++) begin
      check_eq("q_ready", req_ready, (i < 4) ? 1 : 0);
      check_eq("q_fill", queue_count, i);
      tk = 4'($urandom_range(0, 15));
      req_valid = 1'b1; req_ticket = tk;
      if (i < 4) mq.push_back(tk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("q_full", queue_count, 4);
    serve(4'hA, 1, 12, 5);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); @(negedge clk);
      cur_ticket = mq.pop_front();
      check_eq("q_order", active_ticket, cur_ticket);
      check_eq("q_drain", queue_count, 3 - j);
      check_eq("q_busy", busy, 1);
      serve(cur_ticket, j != 0, (j == 0) ? TMO : int'($urandom_range(0, 25)), 0);
    end

    // Three fast in a row, then reset during a fourth delivery
    for (int k = 0; k < 3; k++) begin push_idle(4'd7); serve(4'd7, 1, 2, 0); end
    push_idle(4'd7);
    req_valid = 1'b1; req_ticket = 4'd1;
    @(negedge clk); req_valid = 1'b0;
    car_delivered = 1'b1; delivered_ticket = 4'd7; rst = 1'b1;
    evs = ev_count;
    @(posedge clk); #1;
    check_eq("rstd_valid", tip_event_valid, 0);
    check_eq("rstd_busy", busy, 0);
    check_eq("rstd_qcount", queue_count, 0);
    check_eq("rstd_tip", tip_delta, 0);
    @(negedge clk); rst = 1'b0; car_delivered = 1'b0;
    m_streak = 0;
    repeat (5) @(negedge clk);
    check_eq("rstd_events", ev_count - evs, 0);
    check_eq("rstd_idle", busy, 0);
    push_idle(4'd4); serve(4'd4, 1, 3, 0);

    // Randomized retrievals
    for (int r = 0; r < 24; r++) begin
      tk = 4'($urandom_range(0, 15));
      e  = $urandom_range(0, 42);
      dl = (e <= TMO) && ($urandom_range(0, 9) != 0);
      dt = ($urandom_range(0, 3) == 0) ? tk ^ 4'($urandom_range(1, 15)) : tk;
      push_idle(tk);
      serve(dt, dl, dl ? e : TMO, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
